// File: rtl/vga_scan_out.sv
// VGA raster timing generator and final pixel compositor.
// Optional build macro VGA_BORDER_EN paints a white alignment border.
module vga_scan_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_DIV  = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       video_on,
  input  logic [7:0] l0_rgb,
  input  logic       l0_imagen,
  input  logic [7:0] l1_rgb,
  input  logic       l1_imagen,
  input  logic [7:0] bg_rgb,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic          von_q, von_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          ft_q, ft_d;
  logic [7:0]    rgb_q, rgb_d;
  logic          pix_tick;
  logic          h_last;
  logic          v_last;
  logic          active;
  logic [7:0]    layer_rgb;
`ifdef VGA_BORDER_EN
  logic          edge_px;
`endif

  // pixel divider: tick on the last clock of each pixel
  always_comb begin
    pix_tick = (div_q == DW'(PIX_DIV - 1));
    div_d    = pix_tick ? '0 : div_q + DW'(1);
  end

  // scan position, advancing one pixel per tick
  always_comb begin
    h_last = (h_q == 10'(H_TOTAL - 1));
    v_last = (v_q == 10'(V_TOTAL - 1));
    h_d    = h_q;
    v_d    = v_q;
    if (pix_tick) begin
      h_d = h_last ? '0 : h_q + 10'd1;
      if (h_last)
        v_d = v_last ? '0 : v_q + 10'd1;
    end
  end

  // layer priority: player over obstacles over background
  always_comb begin
    layer_rgb = bg_rgb;
    unique case (1'b1)
      l1_imagen:               layer_rgb = l1_rgb;
      !l1_imagen && l0_imagen: layer_rgb = l0_rgb;
      default:                 layer_rgb = bg_rgb;
    endcase
  end

  // output stage: pins registered from the pre-increment position
  always_comb begin
    active = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
`ifdef VGA_BORDER_EN
    edge_px = (h_q == '0) || (h_q == 10'(H_ACTIVE - 1)) ||
              (v_q == '0) || (v_q == 10'(V_ACTIVE - 1));
`endif
    von_d = von_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    rgb_d = rgb_q;
    ft_d  = pix_tick && h_last && (v_q == 10'(V_ACTIVE - 1));
    if (pix_tick) begin
      von_d = active;
      hs_d  = !((h_q >= 10'(HS_BEG)) && (h_q < 10'(HS_END)));
      vs_d  = !((v_q >= 10'(VS_BEG)) && (v_q < 10'(VS_END)));
      if (!active)
        rgb_d = '0;
`ifdef VGA_BORDER_EN
      else if (edge_px)
        rgb_d = 8'hFF;
`endif
      else
        rgb_d = layer_rgb;
    end
  end

  // state and pin registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      von_q <= 1'b1;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      ft_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      von_q <= von_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      ft_q  <= ft_d;
      rgb_q <= rgb_d;
    end
  end

  assign hcount     = h_q;
  assign vcount     = v_q;
  assign video_on   = von_q;
  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign frame_tick = ft_q;
  assign red        = rgb_q[7:5];
  assign green      = rgb_q[4:2];
  assign blue       = rgb_q[1:0];

endmodule

// File: tb/tb_vga_scan_out.sv
// Self-checking bench for vga_scan_out with a reduced raster.
// Expectations come from a clock-count reference model.
module tb_vga_scan_out;

  localparam int HA  = 16;
  localparam int HFP = 4;
  localparam int HS  = 6;
  localparam int HBP = 4;
  localparam int VA  = 12;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int DIV = 2;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int LINE  = HT * DIV;
  localparam int FRAME = VT * LINE;
`ifdef VGA_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] hcount, vcount;
  logic       video_on;
  logic [7:0] l0_rgb = '0, l1_rgb = '0, bg_rgb = '0;
  logic       l0_imagen = 1'b0, l1_imagen = 1'b0;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic       hsync, vsync, frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  vga_scan_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .PIX_DIV(DIV)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .hcount(hcount), .vcount(vcount), .video_on(video_on),
    .l0_rgb(l0_rgb), .l0_imagen(l0_imagen),
    .l1_rgb(l1_rgb), .l1_imagen(l1_imagen),
    .bg_rgb(bg_rgb),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
  );

  always #5 clock = ~clock;

  // reference model state: clocks since reset, inputs seen at last tick
  int ncyc = 0;
  logic [7:0] t_l0, t_l1, t_bg;
  logic       t_l0i, t_l1i;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ncyc <= 0;
    end else begin
      if ((ncyc + 1) % DIV == 0) begin
        t_l0  <= l0_rgb;
        t_l1  <= l1_rgb;
        t_bg  <= bg_rgb;
        t_l0i <= l0_imagen;
        t_l1i <= l1_imagen;
      end
      ncyc <= ncyc + 1;
    end
  end

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       von;
    logic       hs;
    logic       vs;
    logic       ft;
    logic [7:0] rgb;
  } exp_t;

  function automatic exp_t model(int n);
    exp_t e;
    int p, q, hq, vq;
    bit act, edg;
    p     = n / DIV;
    e.h   = 10'(p % HT);
    e.v   = 10'((p / HT) % VT);
    e.ft  = 1'b0;
    e.von = 1'b1;
    e.hs  = 1'b1;
    e.vs  = 1'b1;
    e.rgb = '0;
    if (p == 0) return e;
    q  = p - 1;
    hq = q % HT;
    vq = (q / HT) % VT;
    act   = (hq < HA) && (vq < VA);
    edg   = (hq == 0) || (hq == HA - 1) || (vq == 0) || (vq == VA - 1);
    e.von = act;
    e.hs  = !((hq >= HA + HFP) && (hq < HA + HFP + HS));
    e.vs  = !((vq >= VA + VFP) && (vq < VA + VFP + VS));
    if (!act)              e.rgb = 8'h00;
    else if (BORDER && edg) e.rgb = 8'hFF;
    else if (t_l1i)        e.rgb = t_l1;
    else if (t_l0i)        e.rgb = t_l0;
    else                   e.rgb = t_bg;
    e.ft = (n % DIV == 0) && (p % HT == 0) && ((p / HT) % VT == VA);
    return e;
  endfunction

  task automatic drive_random();
    l0_rgb    = 8'($urandom);
    l1_rgb    = 8'($urandom);
    bg_rgb    = 8'($urandom);
    l0_imagen = 1'($urandom);
    l1_imagen = 1'($urandom);
  endtask

  task automatic test_reset();
    drive_random();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({hcount, vcount, video_on, hsync, vsync, frame_tick,
         red, green, blue} !== {10'd0, 10'd0, 4'b1110, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_state: h=%0d v=%0d von=%b hs=%b vs=%b ft=%b rgb=%h want 0 0 1 1 1 0 00",
               hcount, vcount, video_on, hsync, vsync, frame_tick,
               {red, green, blue});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_hsync_timing();
    int fall1, rise1, fall2;
    logic prev;
    fall1 = -1; rise1 = -1; fall2 = -1;
    prev  = 1'b1;
    while (ncyc < 2 * LINE) begin
      @(negedge clock);
      if (prev && !hsync) begin
        if (fall1 < 0) fall1 = ncyc;
        else if (fall2 < 0) fall2 = ncyc;
      end
      if (!prev && hsync && rise1 < 0) rise1 = ncyc;
      prev = hsync;
    end
    n_cmp++;
    if (fall1 !== (HA + HFP) * DIV + DIV) begin
      n_bad++;
      $display("FAIL hsync_first_fall: at %0d want %0d",
               fall1, (HA + HFP) * DIV + DIV);
    end
    n_cmp++;
    if (rise1 - fall1 !== HS * DIV) begin
      n_bad++;
      $display("FAIL hsync_width: %0d want %0d", rise1 - fall1, HS * DIV);
    end
    n_cmp++;
    if (fall2 - fall1 !== LINE) begin
      n_bad++;
      $display("FAIL line_period: %0d want %0d", fall2 - fall1, LINE);
    end
  endtask

  task automatic test_frame();
    int vfall, vrise, nft;
    int ft_at[2];
    logic prev;
    vfall = -1; vrise = -1; nft = 0;
    ft_at[0] = -1; ft_at[1] = -1;
    prev = vsync;
    while (ncyc < 2 * FRAME + LINE) begin
      @(negedge clock);
      if (prev && !vsync && vfall < 0) vfall = ncyc;
      if (!prev && vsync && vfall >= 0 && vrise < 0) vrise = ncyc;
      prev = vsync;
      if (frame_tick) begin
        if (nft < 2) ft_at[nft] = ncyc;
        nft++;
        n_cmp++;
        if (hcount !== 10'd0 || vcount !== 10'(VA)) begin
          n_bad++;
          $display("FAIL frame_tick_pos: h=%0d v=%0d want 0 %0d",
                   hcount, vcount, VA);
        end
      end
      if (ncyc == FRAME) begin
        n_cmp++;
        if (hcount !== 10'd0 || vcount !== 10'd0) begin
          n_bad++;
          $display("FAIL frame_wrap: h=%0d v=%0d want 0 0", hcount, vcount);
        end
      end
    end
    n_cmp++;
    if (vfall !== ((VA + VFP) * HT + 1) * DIV) begin
      n_bad++;
      $display("FAIL vsync_fall: at %0d want %0d",
               vfall, ((VA + VFP) * HT + 1) * DIV);
    end
    n_cmp++;
    if (vrise - vfall !== VS * LINE) begin
      n_bad++;
      $display("FAIL vsync_width: %0d want %0d", vrise - vfall, VS * LINE);
    end
    n_cmp++;
    if (nft !== 2 || ft_at[0] !== VA * LINE ||
        ft_at[1] !== VA * LINE + FRAME) begin
      n_bad++;
      $display("FAIL frame_tick_count: n=%0d at %0d,%0d want 2 at %0d,%0d",
               nft, ft_at[0], ft_at[1], VA * LINE, VA * LINE + FRAME);
    end
  endtask

  task automatic test_random_scan(int cycles);
    exp_t e, a;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      e = model(ncyc);
      a = {hcount, vcount, video_on, hsync, vsync, frame_tick,
           red, green, blue};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL scan n=%0d: h=%0d v=%0d von=%b hs=%b vs=%b ft=%b rgb=%h want h=%0d v=%0d von=%b hs=%b vs=%b ft=%b rgb=%h",
                 ncyc, a.h, a.v, a.von, a.hs, a.vs, a.ft, a.rgb,
                 e.h, e.v, e.von, e.hs, e.vs, e.ft, e.rgb);
      end
      drive_random();
    end
  endtask

  task automatic test_priority();
    exp_t e;
    logic [7:0] a;
    bg_rgb = 8'h03;
    l0_rgb = 8'hE0;
    l1_rgb = 8'h1C;
    for (int i = 0; i < FRAME; i++) begin
      l1_imagen = 1'($urandom);
      l0_imagen = ($urandom_range(3) != 0);
      @(negedge clock);
      e = model(ncyc);
      a = {red, green, blue};
      n_cmp++;
      if (a !== e.rgb) begin
        n_bad++;
        $display("FAIL priority n=%0d: rgb=%h want %h", ncyc, a, e.rgb);
      end
    end
  endtask

  task automatic test_border();
    exp_t e;
    logic [7:0] a;
    int q, hq, vq;
    bg_rgb = 8'h00;
    l0_imagen = 1'b0;
    l1_imagen = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clock);
      q  = ncyc / DIV - 1;
      hq = q % HT;
      vq = (q / HT) % VT;
      if (q >= 0 && hq < HA && vq < VA &&
          (hq == 0 || hq == HA - 1 || vq == 0 || vq == VA - 1 ||
           (hq == 1 && vq == 1))) begin
        e = model(ncyc);
        a = {red, green, blue};
        n_cmp++;
        if (a !== e.rgb) begin
          n_bad++;
          $display("FAIL border (%0d,%0d): rgb=%h want %h", hq, vq, a, e.rgb);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    guard = 0;
    while (!(hcount == 10'd10 && vcount == 10'd5) && guard < 2 * FRAME) begin
      @(negedge clock);
      drive_random();
      guard++;
    end
    n_cmp++;
    if (guard >= 2 * FRAME) begin
      n_bad++;
      $display("FAIL mid_reset_wait: position (10,5) not reached");
    end
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({hcount, vcount, video_on, hsync, vsync, frame_tick,
         red, green, blue} !== {10'd0, 10'd0, 4'b1110, 8'h00}) begin
      n_bad++;
      $display("FAIL mid_reset_async: h=%0d v=%0d von=%b hs=%b vs=%b ft=%b rgb=%h want 0 0 1 1 1 0 00",
               hcount, vcount, video_on, hsync, vsync, frame_tick,
               {red, green, blue});
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    test_random_scan(FRAME + LINE);
  endtask

  initial begin
    test_reset();
    test_hsync_timing();
    test_frame();
    test_random_scan(2 * FRAME);
    test_priority();
    test_border();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_scan_out.md
# vga_scan_out

Raster timing generator and final pixel compositor for the game display. It produces the `hcount`/`vcount` scan position that every sprite renderer consumes. It takes back those renderers' registered colour and `imagen` outputs, resolves layer priority against a background colour, and drives the VGA connector pins with aligned sync. It also issues a once-per-frame tick that game logic uses to update sprite X/Y during vertical blanking.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `PIX_DIV`, 2, clock cycles per pixel (legal values ≥ 2)

Ports:
- `clock`  in  1  system clock (50 MHz)
- `reset_n`  in  1  asynchronous active-low reset
- `hcount`  out  10  current pixel column, 0..H_TOTAL-1
- `vcount`  out  10  current line, 0..V_TOTAL-1
- `video_on`  out  1  high when hcount < H_ACTIVE and vcount < V_ACTIVE
- `l0_rgb`  in  8  layer 0 colour {R[2:0],G[2:0],B[1:0]} (obstacles)
- `l0_imagen`  in  1  layer 0 pixel opaque
- `l1_rgb`  in  8  layer 1 colour (player)
- `l1_imagen`  in  1  layer 1 pixel opaque
- `bg_rgb`  in  8  background colour
- `red`  out  3  VGA red
- `green`  out  3  VGA green
- `blue`  out  2  VGA blue
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `frame_tick`  out  1  one-clock pulse at start of vertical blanking

## Operation
- Timing constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Pixel divider: a counter runs 0..PIX_DIV-1. `pix_tick` is asserted when the divider equals PIX_DIV-1.
- On `pix_tick`:
  - `hcount` increments. At H_TOTAL-1 it wraps to 0 and `vcount` increments.
  - `vcount` wraps to 0 from V_TOTAL-1.
- Scan-stage sync for position (h, v):
  - hsync low iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, i.e. columns 656..751.
  - vsync low iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, i.e. lines 490..491.
- Alignment: sprite renderers register their outputs one clock after `hcount` changes, so those outputs are stable before the next `pix_tick`.
- On `pix_tick`, the output stage registers:
  - sync and `video_on` computed from the current (pre-increment) position;
  - colour selected from the layer inputs.
  - Result: pins lag `hcount` by exactly one pixel.
- Colour priority:
  - `l1_imagen` → `l1_rgb`;
  - else `l0_imagen` → `l0_rgb`;
  - else `bg_rgb`.
  - Outside the active area, colour is forced to 0 regardless of layer inputs.
- `frame_tick` is high for exactly one clock: the clock after the `pix_tick` on which the position becomes (0, V_ACTIVE).

## Timing
- Reset values:
  - `hcount`, `vcount`, and the divider = 0;
  - `video_on` = 1 (position 0,0 is active);
  - `hsync` = `vsync` = 1;
  - `red`/`green`/`blue` = 0;
  - `frame_tick` = 0.
- Reset asserted mid-frame: all of the above take effect immediately (asynchronous). The first `pix_tick` occurs PIX_DIV clocks after reset release.
- Counters and registered outputs change only on `pix_tick` clocks. `frame_tick` is the only output that changes on a non-tick clock: it is cleared there.
- Line period = H_TOTAL·PIX_DIV clocks (1600). Frame period = V_TOTAL × line period (840 000 clocks).
- Simultaneous wrap at (H_TOTAL-1, V_TOTAL-1): both counters return to 0 on the same tick, and no `frame_tick` is issued.
- Layer inputs are sampled only on `pix_tick`. Changes between ticks have no effect.

## Configuration
- `VGA_BORDER_EN`:
  - Defined: any active pixel with h = 0, h = H_ACTIVE-1, v = 0 or v = V_ACTIVE-1 outputs 8'hFF (white), overriding all layers. Used for monitor alignment.
  - Undefined: no border logic is compiled, and edge pixels follow normal priority.

## Test plan
- Reset release, then count clocks: first `hsync` fall after 656·2 = 1312 clocks plus one pixel of pipeline (1314 clocks); hsync stays low for 192 clocks; line period is 1600 clocks.
- Run one full frame: vsync is low for exactly 2 lines (3200 clocks) starting at line 490; `frame_tick` occurs once per 840 000 clocks, one clock after position (0, 480).
- Hold `bg_rgb`=8'h03, `l0_rgb`=8'hE0 with `l0_imagen`=1, `l1_rgb`=8'h1C with `l1_imagen` toggling: outputs are 1C when `l1_imagen`=1, E0 when only `l0_imagen`=1, 03 when both are 0. Colour is always 0 during blanking.
- Assert `reset_n` low at (h=300, v=200) for 3 clocks: counters read 0 immediately, sync goes high, colour goes 0; the frame restarts cleanly.
- With `VGA_BORDER_EN`, `bg_rgb`=8'h00: pixels (0,y), (639,y), (x,0) and (x,479) output FF, and pixel (1,1) outputs 00. Without the macro, all four edges output 00.
